// File: rtl/gf_2to128_multiplier_digit_serial_if.sv
// Handshake bundle for the digit-serial GF(2^128) multiplier: an operand
// channel (valid/ready with X and Y) and a result channel (valid/ready with Z).
interface gf_2to128_multiplier_digit_serial_if #(
    parameter int NB_DATA = 128
);
    logic               i_valid;
    logic               o_ready;
    logic [NB_DATA-1:0] i_data_x;
    logic [NB_DATA-1:0] i_data_y;
    logic               o_valid;
    logic               i_ready;
    logic [NB_DATA-1:0] o_data_z;

    // Upstream sequencer / downstream accumulator side
    modport master (
        output i_valid, i_data_x, i_data_y, i_ready,
        input  o_ready, o_valid, o_data_z
    );

    // Multiplier side
    modport slave (
        input  i_valid, i_data_x, i_data_y, i_ready,
        output o_ready, o_valid, o_data_z
    );
endinterface

// File: rtl/gf_2to128_multiplier_digit_serial.sv
// Digit-serial GF(2^128) multiplier, GCM bit ordering (bit 127 = x^0).
// Z = X*Y mod x^128 + x^7 + x^2 + x + 1. NB_DIGIT bits of X are consumed per
// clock, so one product takes NB_DATA/NB_DIGIT busy cycles.
module gf_2to128_multiplier_digit_serial #(
    parameter int NB_DATA  = 128,
    parameter int NB_DIGIT = 8
) (
    input  logic                                i_clock,
    input  logic                                i_reset,
    gf_2to128_multiplier_digit_serial_if.slave  bus
);

    localparam bit BAD_CONF = (NB_DATA != 128) || (NB_DIGIT < 1) ||
                              (NB_DATA % NB_DIGIT != 0);
    localparam int N_CYCLES = NB_DATA / NB_DIGIT;
    localparam int CNT_W    = (N_CYCLES > 1) ? $clog2(N_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CYCLES - 1);
    // Reduction constant: x^0 + x^1 + x^2 + x^7 in reflected bit order
    localparam logic [NB_DATA-1:0] R_POLY = {8'he1, {(NB_DATA-8){1'b0}}};

    generate
        if (BAD_CONF) begin : g_bad_conf
            $error("gf_2to128_multiplier_digit_serial: NB_DATA must be 128 and divisible by NB_DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NB_DATA-1:0] x_q;
    logic [NB_DATA-1:0] v_q;
    logic [NB_DATA-1:0] z_q;
    logic [NB_DATA-1:0] res_q;
    logic               valid_q;

    logic [NB_DATA-1:0] x_d;
    logic [NB_DATA-1:0] v_d;
    logic [NB_DATA-1:0] z_d;
    logic               ready_s;
    logic               accept_s;

    // Operand ready: idle, or finishing a result that is consumed this edge
    always_comb begin
        ready_s  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.i_ready);
        accept_s = bus.i_valid && ready_s;
    end

    // One digit: NB_DIGIT cascaded conditional-add / multiply-by-x steps, X MSB first
    always_comb begin
        x_d = x_q;
        v_d = v_q;
        z_d = z_q;
        for (int k = 0; k < NB_DIGIT; k++) begin
            z_d = z_d ^ (x_d[NB_DATA-1] ? v_d : {NB_DATA{1'b0}});
            v_d = (v_d >> 1'b1) ^ (v_d[0] ? R_POLY : {NB_DATA{1'b0}});
            x_d = x_d << 1'b1;
        end
    end

    // Control FSM and datapath registers; result register only loads on entry to DONE
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            v_q     <= '0;
            z_q     <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        x_q     <= bus.i_data_x;
                        v_q     <= bus.i_data_y;
                        z_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_BUSY;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    x_q   <= x_d;
                    v_q   <= v_d;
                    z_q   <= z_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        res_q   <= z_d;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        if (accept_s) begin
                            x_q     <= bus.i_data_x;
                            v_q     <= bus.i_data_y;
                            z_q     <= '0;
                            cnt_q   <= '0;
                            state_q <= ST_BUSY;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready  = ready_s;
    assign bus.o_valid  = valid_q;
    assign bus.o_data_z = res_q;

endmodule

// File: tb/tb_gf_2to128_multiplier_digit_serial.sv
// Self-checking bench for gf_2to128_multiplier_digit_serial. The reference
// multiplies reflected polynomials by plain carry-less multiplication and
// reduces the 255-bit product, independent of the shift-register algorithm.
module tb_gf_2to128_multiplier_digit_serial;

    localparam int NB_DATA = 128;
    localparam int N8      = 16;   // cycles per product for the main NB_DIGIT=8 instance
    localparam int NREG    = 1000;

    logic clk;
    logic drv_reset;
    logic drv_valid;
    logic drv_ready;
    logic [NB_DATA-1:0] drv_x;
    logic [NB_DATA-1:0] drv_y;

    int n_checks;
    int n_errors;

    gf_2to128_multiplier_digit_serial_if #(.NB_DATA(NB_DATA)) bus8 ();
    gf_2to128_multiplier_digit_serial_if #(.NB_DATA(NB_DATA)) bus1 ();
    gf_2to128_multiplier_digit_serial_if #(.NB_DATA(NB_DATA)) bus128 ();

    assign bus8.i_valid    = drv_valid;
    assign bus8.i_ready    = drv_ready;
    assign bus8.i_data_x   = drv_x;
    assign bus8.i_data_y   = drv_y;
    assign bus1.i_valid    = drv_valid;
    assign bus1.i_ready    = drv_ready;
    assign bus1.i_data_x   = drv_x;
    assign bus1.i_data_y   = drv_y;
    assign bus128.i_valid  = drv_valid;
    assign bus128.i_ready  = drv_ready;
    assign bus128.i_data_x = drv_x;
    assign bus128.i_data_y = drv_y;

    gf_2to128_multiplier_digit_serial #(.NB_DATA(NB_DATA), .NB_DIGIT(8)) dut8 (
        .i_clock (clk), .i_reset (drv_reset), .bus (bus8));
    gf_2to128_multiplier_digit_serial #(.NB_DATA(NB_DATA), .NB_DIGIT(1)) dut1 (
        .i_clock (clk), .i_reset (drv_reset), .bus (bus1));
    gf_2to128_multiplier_digit_serial #(.NB_DATA(NB_DATA), .NB_DIGIT(128)) dut128 (
        .i_clock (clk), .i_reset (drv_reset), .bus (bus128));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NB_DATA-1:0] x;
        logic [NB_DATA-1:0] y;
        logic [NB_DATA-1:0] z;
    } vec_t;

    function automatic logic [127:0] gf_ref(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] pa, pb, r;
        logic [254:0] p;
        for (int i = 0; i < 128; i++) begin
            pa[i] = a[127-i];
            pb[i] = b[127-i];
        end
        p = '0;
        for (int i = 0; i < 128; i++)
            if (pa[i]) p = p ^ ({127'd0, pb} << i);
        // x^128 == x^7 + x^2 + x + 1
        for (int i = 254; i >= 128; i--) begin
            if (p[i]) begin
                p[i]     = 1'b0;
                p[i-121] = ~p[i-121];
                p[i-126] = ~p[i-126];
                p[i-127] = ~p[i-127];
                p[i-128] = ~p[i-128];
            end
        end
        for (int i = 0; i < 128; i++) r[127-i] = p[i];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts edges until o_valid of the main instance rises (i_ready held low)
    task automatic wait_result(output logic [127:0] z, output int lat);
        lat = 0;
        while (!bus8.o_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        z = bus8.o_data_z;
    endtask

    // Presents one operand pair, waits for acceptance, then waits for the result
    task automatic run_op(input logic [127:0] x, input logic [127:0] y,
                          output logic [127:0] z, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        drv_valid = 1'b1; drv_x = x; drv_y = y; drv_ready = 1'b0;
        #1;
        while (!bus8.o_ready && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        drv_valid = 1'b0;
        wait_result(z, lat);
    endtask

    task automatic consume();
        @(negedge clk);
        drv_ready = 1'b1;
        @(posedge clk); #1;
        drv_ready = 1'b0;
    endtask

    initial begin
        vec_t tbl[6];
        logic [127:0] z, za, bx, by, ex;
        logic [127:0] px[4], py[4];
        logic [127:0] exp_q[$];
        int lat, lat1, lat8, lat128, n;
        logic [127:0] z1, z8, z128;
        logic acc, cons;

        n_checks = 0; n_errors = 0;
        drv_reset = 1'b1; drv_valid = 1'b0; drv_ready = 1'b0;
        drv_x = '0; drv_y = '0;

        tbl[0] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000,
                   128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210,
                   128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210};
        tbl[1] = '{tbl[0].y, tbl[0].x, tbl[0].y};
        tbl[2] = '{128'h0388dace60b6a392f328c2b971b2fe78,
                   128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                   128'h5e2ec746917062882c85b0685353deb7};
        tbl[3] = '{128'd0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'd0};
        for (int i = 4; i < 6; i++) begin
            tbl[i].x = rnd128();
            tbl[i].y = rnd128();
            tbl[i].z = gf_ref(tbl[i].x, tbl[i].y);
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        drv_reset = 1'b0;
        #1;
        chk("rst_o_valid", {127'd0, bus8.o_valid}, 128'd0);
        chk("rst_o_ready", {127'd0, bus8.o_ready}, 128'd1);
        chk("rst_o_data_z", bus8.o_data_z, 128'd0);

        // GCM vector on NB_DIGIT = 1, 8, 128 concurrently; latency per instance
        @(negedge clk);
        drv_valid = 1'b1; drv_x = tbl[2].x; drv_y = tbl[2].y; drv_ready = 1'b0;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        lat1 = -1; lat8 = -1; lat128 = -1; n = 0;
        while ((lat1 < 0 || lat8 < 0 || lat128 < 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (bus1.o_valid && lat1 < 0)     begin lat1 = n;   z1 = bus1.o_data_z;   end
            if (bus8.o_valid && lat8 < 0)     begin lat8 = n;   z8 = bus8.o_data_z;   end
            if (bus128.o_valid && lat128 < 0) begin lat128 = n; z128 = bus128.o_data_z; end
        end
        chk("gcm_lat_d1",   128'(lat1),   128'd128);
        chk("gcm_lat_d8",   128'(lat8),   128'd16);
        chk("gcm_lat_d128", 128'(lat128), 128'd1);
        chk("gcm_z_d1",   (lat1 < 0)   ? 128'd0 : z1,   tbl[2].z);
        chk("gcm_z_d8",   (lat8 < 0)   ? 128'd0 : z8,   tbl[2].z);
        chk("gcm_z_d128", (lat128 < 0) ? 128'd0 : z128, tbl[2].z);
        consume();

        // Table-driven vectors on the main instance
        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].x, tbl[i].y, z, lat);
            chk($sformatf("tbl%0d_z", i), z, tbl[i].z);
            chk($sformatf("tbl%0d_lat", i), 128'(lat), 128'(N8));
            consume();
        end

        // Back-to-back with i_ready high: spacing is N busy cycles plus the
        // DONE cycle in which the next pair is accepted
        for (int i = 0; i < 4; i++) begin px[i] = rnd128(); py[i] = rnd128(); end
        begin
            int idx, nres, cyc, last;
            idx = 0; nres = 0; cyc = 0; last = 0;
            for (int c = 0; c < 300 && nres < 4; c++) begin
                @(negedge clk);
                drv_valid = (idx < 4);
                drv_x = px[(idx < 4) ? idx : 3];
                drv_y = py[(idx < 4) ? idx : 3];
                drv_ready = 1'b1;
                #1;
                if (bus8.o_valid) chk("b2b_ready_in_done", {127'd0, bus8.o_ready}, 128'd1);
                acc = drv_valid && bus8.o_ready;
                @(posedge clk); #1;
                cyc++;
                if (acc) idx++;
                if (bus8.o_valid) begin
                    chk($sformatf("b2b_z%0d", nres), bus8.o_data_z, gf_ref(px[nres], py[nres]));
                    if (nres > 0) chk("b2b_spacing", 128'(cyc - last), 128'(N8 + 1));
                    last = cyc;
                    nres++;
                end
            end
            chk("b2b_count", 128'(nres), 128'd4);
            drv_valid = 1'b0;
            consume();
        end

        // Backpressure: DONE held 10 cycles with new operands waiting
        bx = rnd128(); by = rnd128();
        run_op(rnd128(), rnd128(), za, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drv_valid = 1'b1; drv_x = bx; drv_y = by; drv_ready = 1'b0;
            #1;
            chk("bp_ready_low", {127'd0, bus8.o_ready}, 128'd0);
            chk("bp_valid_high", {127'd0, bus8.o_valid}, 128'd1);
            chk("bp_z_stable", bus8.o_data_z, za);
        end
        @(negedge clk);
        drv_ready = 1'b1;
        #1;
        chk("bp_release_ready", {127'd0, bus8.o_ready}, 128'd1);
        @(posedge clk); #1;
        drv_valid = 1'b0; drv_ready = 1'b0;
        wait_result(z, lat);
        chk("bp_new_z", z, gf_ref(bx, by));
        chk("bp_new_lat", 128'(lat), 128'(N8));
        consume();

        // Reset while the counter sits at 5
        @(negedge clk);
        drv_valid = 1'b1; drv_x = rnd128(); drv_y = rnd128();
        @(posedge clk); #1;
        drv_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        drv_reset = 1'b1;
        #1;
        chk("rst_mid_o_valid", {127'd0, bus8.o_valid}, 128'd0);
        chk("rst_mid_o_data_z", bus8.o_data_z, 128'd0);
        @(negedge clk);
        drv_reset = 1'b0;
        #1;
        chk("rst_mid_o_ready", {127'd0, bus8.o_ready}, 128'd1);
        run_op(128'd0, 128'd0, z, lat);
        chk("rst_zero_z", z, 128'd0);
        chk("rst_zero_lat", 128'(lat), 128'(N8));
        consume();

        // Random regression with valid/ready throttling and a scoreboard
        begin
            int acc_n, cons_n;
            acc_n = 0; cons_n = 0;
            for (int c = 0; c < 60000 && cons_n < NREG; c++) begin
                @(negedge clk);
                if (!drv_valid && acc_n < NREG && $urandom_range(0, 9) < 7) begin
                    drv_valid = 1'b1; drv_x = rnd128(); drv_y = rnd128();
                end
                drv_ready = ($urandom_range(0, 9) < 6);
                #1;
                acc  = drv_valid && bus8.o_ready;
                cons = bus8.o_valid && drv_ready;
                if (cons) begin
                    if (exp_q.size() == 0) begin
                        chk("rnd_unexpected_result", bus8.o_data_z, ~bus8.o_data_z);
                    end else begin
                        ex = exp_q.pop_front();
                        chk("rnd_z", bus8.o_data_z, ex);
                    end
                    cons_n++;
                end
                if (acc) begin
                    exp_q.push_back(gf_ref(drv_x, drv_y));
                    acc_n++;
                end
                @(posedge clk); #1;
                if (acc) drv_valid = 1'b0;
            end
            chk("rnd_accepted", 128'(acc_n), 128'(NREG));
            chk("rnd_consumed", 128'(cons_n), 128'(NREG));
            chk("rnd_leftover", 128'(exp_q.size()), 128'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
